// File: rtl/morph_pkg.sv
// Shared definitions for the binary 3x3 morphology blocks (erosion and dilation).
package morph_pkg;

  localparam int MORPH_LAT = 3;
  localparam int DIM_W     = 11;

  // Bit positions of a window row: left (px1), centre (px2), right (px3).
  localparam int TAP_L = 2;
  localparam int TAP_C = 1;
  localparam int TAP_R = 0;

  typedef struct packed {
    logic [2:0] top;
    logic [2:0] mid;
    logic [2:0] bot;
  } window_t;

  function automatic logic row_and(input logic [2:0] row, input logic centre_only);
    return centre_only ? row[TAP_C] : &row;
  endfunction

endpackage

// File: rtl/bit_window_3x3.sv
// 3x3 binary window generator: pixel/line counters, two line-buffer RAMs,
// neutral (white) padding at the top and left edges, and the p11..p33 registers.
module bit_window_3x3
  import morph_pkg::*;
#(
  parameter logic [DIM_W-1:0] IMG_HDISP = 11'd640,
  parameter logic [DIM_W-1:0] IMG_VDISP = 11'd480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_vsync,
  input  logic       in_href,
  input  logic       in_bit,
  output logic [8:0] win,
  output logic       win_vsync,
  output logic       win_href,
  output logic       win_centre_ok
);

  localparam int DEPTH = int'(IMG_HDISP);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic lb0_mem [DEPTH];
  logic lb1_mem [DEPTH];

  logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
  logic             vsync_q, vsync_d, href_q, href_d;
  logic             centre_ok_q, centre_ok_d;
  window_t          win_q, win_d;

  logic [AW-1:0] addr;
  logic          in_line, wr_en, href_fall, top_tap, mid_tap;

  // Taps from rows above the frame, or from columns left of the line start, read as white.
  always_comb begin
    in_line   = x_q < IMG_HDISP;
    addr      = x_q[AW-1:0];
    wr_en     = in_href && in_line;
    href_fall = href_q && !in_href;

    x_d = '0;
    if (in_href) x_d = in_line ? x_q + 1'b1 : x_q;

    y_d = y_q;
    if (!in_vsync) y_d = '0;
    else if (href_fall && (y_q < IMG_VDISP)) y_d = y_q + 1'b1;

    top_tap = (y_q >= DIM_W'(2) && in_line) ? lb1_mem[addr] : 1'b1;
    mid_tap = (y_q >= DIM_W'(1) && in_line) ? lb0_mem[addr] : 1'b1;

    win_d       = win_q;
    centre_ok_d = 1'b0;
    if (in_href) begin
      centre_ok_d = (x_q != '0) && (y_q != '0);
      if (x_q == '0) begin
        win_d.top = {2'b11, top_tap};
        win_d.mid = {2'b11, mid_tap};
        win_d.bot = {2'b11, in_bit};
      end else begin
        win_d.top = {win_q.top[TAP_C], win_q.top[TAP_R], top_tap};
        win_d.mid = {win_q.mid[TAP_C], win_q.mid[TAP_R], mid_tap};
        win_d.bot = {win_q.bot[TAP_C], win_q.bot[TAP_R], in_bit};
      end
    end

    vsync_d = in_vsync;
    href_d  = in_href;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      centre_ok_q <= 1'b0;
      win_q       <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      centre_ok_q <= centre_ok_d;
      win_q       <= win_d;
    end
  end

  // Line RAMs are not reset; the row-counter gating above hides stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb1_mem[addr] <= lb0_mem[addr];
      lb0_mem[addr] <= in_bit;
    end
  end

  assign win           = win_q;
  assign win_vsync     = vsync_q;
  assign win_href      = href_q;
  assign win_centre_ok = centre_ok_q;

endmodule

// File: rtl/bit_erosion_detector.sv
// Binary 3x3 erosion over a vsync/href/bit stream, 3-cycle latency.
// Define BIT_EROSION_CROSS_EN to erode with the 5-tap cross instead of the full square.
module bit_erosion_detector
  import morph_pkg::*;
#(
  parameter logic [DIM_W-1:0] IMG_HDISP = 11'd640,
  parameter logic [DIM_W-1:0] IMG_VDISP = 11'd480
) (
  input  logic clk,
  input  logic rst,
  input  logic per_frame_vsync,
  input  logic per_frame_href,
  input  logic per_img_Bit,
  output logic post_frame_vsync,
  output logic post_frame_href,
  output logic post_img_Bit
);

`ifdef BIT_EROSION_CROSS_EN
  localparam logic CROSS = 1'b1;
`else
  localparam logic CROSS = 1'b0;
`endif

  logic [8:0] win_bits;
  window_t    win;
  logic       win_vsync, win_href, win_centre_ok;

  logic [2:0]           row_q, row_d;
  logic                 ok_q, ok_d, bit_q, bit_d;
  logic [MORPH_LAT-2:0] vsync_q, vsync_d, href_q, href_d;

  bit_window_3x3 #(
    .IMG_HDISP(IMG_HDISP),
    .IMG_VDISP(IMG_VDISP)
  ) u_window (
    .clk          (clk),
    .rst          (rst),
    .in_vsync     (per_frame_vsync),
    .in_href      (per_frame_href),
    .in_bit       (per_img_Bit),
    .win          (win_bits),
    .win_vsync    (win_vsync),
    .win_href     (win_href),
    .win_centre_ok(win_centre_ok)
  );

  // Undefined centres (output row 0 or column 0) carry ok=0 and so emit black.
  always_comb begin
    win     = win_bits;
    row_d   = {row_and(win.top, CROSS), row_and(win.mid, 1'b0), row_and(win.bot, CROSS)};
    ok_d    = win_centre_ok;
    bit_d   = (&row_q) && ok_q;
    vsync_d = {vsync_q[MORPH_LAT-3:0], win_vsync};
    href_d  = {href_q[MORPH_LAT-3:0], win_href};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q   <= '0;
      ok_q    <= 1'b0;
      bit_q   <= 1'b0;
      vsync_q <= '0;
      href_q  <= '0;
    end else begin
      row_q   <= row_d;
      ok_q    <= ok_d;
      bit_q   <= bit_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
    end
  end

  assign post_frame_vsync = vsync_q[MORPH_LAT-2];
  assign post_frame_href  = href_q[MORPH_LAT-2];
  assign post_img_Bit     = bit_q;

endmodule

// File: tb/tb_bit_erosion_detector.sv
// Self-checking bench for bit_erosion_detector on an 8x6 image, both structuring elements.
module tb_bit_erosion_detector;

  localparam logic [10:0] HD = 11'd8;
  localparam logic [10:0] VD = 11'd6;
  localparam int W = 8;
  localparam int H = 6;

`ifdef BIT_EROSION_CROSS_EN
  localparam bit CROSS = 1'b1;
`else
  localparam bit CROSS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic per_frame_vsync = 1'b0;
  logic per_frame_href = 1'b0;
  logic per_img_Bit = 1'b0;
  logic post_frame_vsync, post_frame_href, post_img_Bit;

  always #5 clk = ~clk;

  bit_erosion_detector #(.IMG_HDISP(HD), .IMG_VDISP(VD)) dut (
    .clk             (clk),
    .rst             (rst),
    .per_frame_vsync (per_frame_vsync),
    .per_frame_href  (per_frame_href),
    .per_img_Bit     (per_img_Bit),
    .post_frame_vsync(post_frame_vsync),
    .post_frame_href (post_frame_href),
    .post_img_Bit    (post_img_Bit)
  );

  typedef struct {
    logic vs;
    logic hr;
    logic bv;
    logic known;
    int   oy;
    int   ox;
  } rec_t;

  rec_t pipe [$];
  rec_t n_rec, e_rec;
  int   img     [H][W];
  int   out_img [H][W];
  int   cur_row = 0;
  int   cur_col = 0;
  int   total = 0;
  int   bad = 0;

  task automatic checkOutput(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b, wanted %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkLit(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, wanted %0d", name, act, exp);
    end
  endtask

  // Erosion of the input image at output position (oy,x): centre is (oy-1, ox-1).
  // Unknown pixels (value 2) make the result unknown unless some known tap is black.
  function automatic void model_at(input int oy, input int ox, output logic v, output logic known);
    bit unk = 1'b0;
    v = 1'b1;
    known = 1'b1;
    if (oy == 0 || ox == 0) begin
      v = 1'b0;
      return;
    end
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int r, c;
        r = oy - 1 + dr;
        c = ox - 1 + dc;
        if (CROSS && dr != 0 && dc != 0) continue;
        if (r < 0 || c < 0) continue;
        if (img[r][c] == 2) unk = 1'b1;
        else if (img[r][c] == 0) v = 1'b0;
      end
    end
    known = (v == 1'b0) || !unk;
  endfunction

  function automatic logic pix(input int kind, input int r, input int c);
    case (kind)
      1:       return !(r == 3 && c == 3);
      2:       return (r == 2 && c == 4);
      default: return 1'b1;
    endcase
  endfunction

  // Compare process: three-deep delay line of expected records, checked every cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pipe.delete();
        checkOutput("rst_vsync", post_frame_vsync, 1'b0);
        checkOutput("rst_href", post_frame_href, 1'b0);
        checkOutput("rst_bit", post_img_Bit, 1'b0);
        continue;
      end
      n_rec.vs = per_frame_vsync;
      n_rec.hr = per_frame_href;
      n_rec.oy = cur_row;
      n_rec.ox = cur_col;
      if (per_frame_href) model_at(cur_row, cur_col, n_rec.bv, n_rec.known);
      else begin
        n_rec.bv = 1'b0;
        n_rec.known = 1'b1;
      end
      pipe.push_back(n_rec);
      if (pipe.size() > 3) void'(pipe.pop_front());
      if (pipe.size() == 3) e_rec = pipe[0];
      else begin
        e_rec.vs = 1'b0;
        e_rec.hr = 1'b0;
        e_rec.bv = 1'b0;
        e_rec.known = 1'b1;
        e_rec.oy = 0;
        e_rec.ox = 0;
      end
      checkOutput("post_vsync", post_frame_vsync, e_rec.vs);
      checkOutput("post_href", post_frame_href, e_rec.hr);
      if (e_rec.known)
        checkOutput($sformatf("bit(%0d,%0d)", e_rec.oy, e_rec.ox), post_img_Bit, e_rec.bv);
      if (e_rec.hr && e_rec.known && e_rec.oy < H && e_rec.ox < W)
        out_img[e_rec.oy][e_rec.ox] = int'(post_img_Bit);
    end
  end

  task automatic applyStimulus(input logic vs, input logic hr, input logic b,
                               input int r, input int c);
    @(negedge clk);
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_img_Bit     = b;
    cur_row = r;
    cur_col = c;
    if (hr) img[r][c] = int'(b);
  endtask

  task automatic midReset();
    #2;
    rst = 1'b1;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_img_Bit     = 1'b0;
    #1;
    checkOutput("async_rst_vsync", post_frame_vsync, 1'b0);
    checkOutput("async_rst_href", post_frame_href, 1'b0);
    checkOutput("async_rst_bit", post_img_Bit, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(input int kind, input int first_len, input int nrows,
                            input int rst_row, input int rst_col);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[r][c] = 2;
        out_img[r][c] = -1;
      end
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    for (int r = 0; r < nrows; r++) begin
      int len;
      len = (r == 0) ? first_len : W;
      for (int c = 0; c < len; c++) begin
        applyStimulus(1'b1, 1'b1, pix(kind, r, c), r, c);
        if (r == rst_row && c == rst_col) begin
          midReset();
          return;
        end
      end
      applyStimulus(1'b1, 1'b0, 1'b0, r, 0);
    end
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic pinAllOnes(input string tag);
    checkLit({tag, "_row0"}, out_img[0][3], 0);
    checkLit({tag, "_col0"}, out_img[3][0], 0);
    checkLit({tag, "_inner"}, out_img[2][5], 1);
    checkLit({tag, "_corner"}, out_img[5][7], 1);
  endtask

  initial begin
    #1;
    rst = 1'b1;
    #1;
    checkOutput("reset_vsync", post_frame_vsync, 1'b0);
    checkOutput("reset_href", post_frame_href, 1'b0);
    checkOutput("reset_bit", post_img_Bit, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    $display("[TB] all-ones frame");
    send_frame(0, W, H, -1, -1);
    pinAllOnes("ones");

    $display("[TB] single black pixel at (3,3)");
    send_frame(1, W, H, -1, -1);
    checkLit("blk_44", out_img[4][4], 0);
    checkLit("blk_43", out_img[4][3], 0);
    checkLit("blk_33", out_img[3][3], CROSS ? 1 : 0);
    checkLit("blk_55", out_img[5][5], CROSS ? 1 : 0);
    checkLit("blk_24", out_img[2][4], 1);
    checkLit("blk_46", out_img[4][6], 1);

    $display("[TB] isolated white pixel at (2,4)");
    send_frame(2, W, H, -1, -1);
    checkLit("iso_35", out_img[3][5], 0);
    checkLit("iso_34", out_img[3][4], 0);

    $display("[TB] three lines with one-cycle gaps");
    send_frame(0, W, 3, -1, -1);
    checkLit("short3_26", out_img[2][6], 1);

    $display("[TB] reset mid-frame then fresh frame");
    send_frame(0, W, H, 2, 4);
    send_frame(0, W, H, -1, -1);
    pinAllOnes("after_rst");

    $display("[TB] short first line");
    send_frame(0, 5, H, -1, -1);
    checkLit("short_11", out_img[1][1], 1);
    checkLit("short_14", out_img[1][4], 1);
    checkLit("short_23", out_img[2][3], 1);
    checkLit("short_02", out_img[0][2], 0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
